// File: rtl/project3.sv
// project3: 16-bit signed two-operand calculator ALU, single-cycle compute,
// registered result and overflow/error flag.
`default_nettype none

module project3 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Opcode,
  output logic [WIDTH-1:0] print,
  output logic             ov
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]          sum;
  logic [WIDTH-1:0]          diff;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]          div_b;
  logic signed [WIDTH-1:0]   quot;
  logic                      b_zero;
  logic                      div_ovf;

  logic [WIDTH-1:0] print_d, print_q;
  logic             ov_d, ov_q;

  assign sum     = A + B;
  assign diff    = A - B;
  assign prod    = $signed(A) * $signed(B);
  assign b_zero  = (B == '0);
  assign div_ovf = (A == MIN_VAL) && (B == '1);
  // Substitute a harmless divisor so the divider never sees zero.
  assign div_b   = b_zero ? ONE : B;
  assign quot    = $signed(A) / $signed(div_b);

  always_comb begin
    print_d = '0;
    ov_d    = 1'b0;
    case (Opcode)
      OP_ADD: begin
        print_d = sum;
        ov_d    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        print_d = diff;
        ov_d    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL: begin
        print_d = prod[WIDTH-1:0];
        ov_d    = (prod != {{WIDTH{prod[WIDTH-1]}}, prod[WIDTH-1:0]});
      end
      OP_DIV: begin
        if (b_zero) begin
          print_d = '0;
          ov_d    = 1'b1;
        end else if (div_ovf) begin
          print_d = MIN_VAL;
          ov_d    = 1'b1;
        end else begin
          print_d = quot;
        end
      end
      OP_INC: begin
        print_d = A + ONE;
        ov_d    = (A == MAX_VAL);
      end
      OP_DEC: begin
        print_d = A - ONE;
        ov_d    = (A == MIN_VAL);
      end
      OP_AND:  print_d = A & B;
      OP_XOR:  print_d = A ^ B;
      OP_OR:   print_d = A | B;
      OP_NOT:  print_d = ~A;
      default: begin
        print_d = '0;
        ov_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      print_q <= '0;
      ov_q    <= 1'b0;
    end else begin
      print_q <= print_d;
      ov_q    <= ov_d;
    end
  end

  assign print = print_q;
  assign ov    = ov_q;

endmodule

`default_nettype wire

// File: tb/tb_project3.sv
// tb_project3: scoreboard bench for project3; expectations queued at drive
// time and checked one cycle later.
`default_nettype none

module tb_project3;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  Opcode;
  logic [15:0] print;
  logic        ov;

  logic        drv_vld;
  int          total;
  int          bad;
  logic [16:0] exp_q[$];
  string       tag_q[$];

  project3 #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .Opcode (Opcode),
    .print  (print),
    .ov     (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input int a, input int b,
                       input int exp_p, input logic exp_ov);
    logic [15:0] p16;
    @(negedge clk);
    A       = a[15:0];
    B       = b[15:0];
    Opcode  = op;
    drv_vld = 1'b1;
    p16     = exp_p[15:0];
    exp_q.push_back({exp_ov, p16});
    tag_q.push_back(tag);
  endtask

  // Each driven operation must surface exactly one edge later.
  always @(posedge clk) begin
    if (drv_vld) begin
      logic [16:0] e;
      string       t;
      #1;
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, "_print"}, {16'd0, print}, {16'd0, e[15:0]});
        chk({t, "_ov"}, {31'd0, ov}, {31'd0, e[16]});
      end
    end
  end

  initial begin
    logic [15:0] ra, rb;
    int          sa, sb, s;
    bit          s_ov;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    drv_vld = 1'b0;
    A       = 16'd100;
    B       = 16'd1;
    Opcode  = 4'd0;

    repeat (2) @(negedge clk);
    chk("reset_print", {16'd0, print}, 32'd0);
    chk("reset_ov", {31'd0, ov}, 32'd0);
    rst_n = 1'b1;

    issue("pre_reset_add", 4'd0, 100, 1, 101, 1'b0);
    @(negedge clk);
    drv_vld = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_print", {16'd0, print}, 32'd0);
    chk("async_reset_ov", {31'd0, ov}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("add_36_25",      4'd0, 36, 25, 61, 1'b0);
    issue("add_12000",      4'd0, 12000, 12000, 24000, 1'b0);
    issue("add_ovf",        4'd0, 32767, 5000, -27769, 1'b1);
    issue("add_neg",        4'd0, -32767, 1, -32766, 1'b0);
    issue("sub_30000",      4'd1, 30000, 2500, 27500, 1'b0);
    issue("sub_ovf",        4'd1, 32000, 33000, -1000, 1'b1);
    issue("mul_zero",       4'd2, 36, 0, 0, 1'b0);
    issue("mul_ovf",        4'd2, 300, -200, 5536, 1'b1);
    issue("mul_neg",        4'd2, -326, 100, -32600, 1'b0);
    issue("div_trunc",      4'd3, -7000, 3, -2333, 1'b0);
    issue("div_by_zero",    4'd3, 6533, 0, 0, 1'b1);
    issue("div_min_m1",     4'd3, -32768, -1, -32768, 1'b1);
    issue("inc_32766",      4'd4, 32766, 77, 32767, 1'b0);
    issue("inc_ovf",        4'd4, 32767, -5, -32768, 1'b1);
    issue("dec_m7000",      4'd5, -7000, 9, -7001, 1'b0);
    issue("dec_m32767",     4'd5, -32767, 0, -32768, 1'b0);
    issue("dec_ovf",        4'd5, -32768, 123, 32767, 1'b1);
    issue("and_36_25",      4'd6, 36, 25, 0, 1'b0);
    issue("xor_36_25",      4'd7, 36, 25, 61, 1'b0);
    issue("or_36_25",       4'd8, 36, 25, 61, 1'b0);
    issue("and_12000",      4'd6, 12000, 12000, 12000, 1'b0);
    issue("xor_12000",      4'd7, 12000, 12000, 0, 1'b0);
    issue("or_neg",         4'd8, -32767, 1, -32767, 1'b0);
    issue("not_36",         4'd9, 36, 999, -37, 1'b0);
    issue("not_m32767",     4'd9, -32767, 0, 32766, 1'b0);
    issue("reserved_12",    4'd12, 5, 5, 0, 1'b0);
    issue("reserved_15",    4'd15, -1, -1, 0, 1'b0);

    // Alternate ADD/SUB every cycle, expectations from wide integer arithmetic.
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) begin
        ra = 16'h7fff;
        rb = 16'h0001;
      end
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      s  = (i % 2 == 0) ? sa + sb : sa - sb;
      s_ov = (s > 32767) || (s < -32768);
      issue((i % 2 == 0) ? "b2b_add" : "b2b_sub", (i % 2 == 0) ? 4'd0 : 4'd1,
            sa, sb, s, s_ov);
    end

    @(negedge clk);
    drv_vld = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/project3.md
Name: project3

Overview:
- 16-bit signed two-operand calculator ALU with a 4-bit opcode: arithmetic, increment/decrement, bitwise logic and complement.
- Produces a registered 16-bit signed result and an overflow/error flag.
- Sits as a leaf datapath block; operands and opcode are sampled every clock, with no handshake.

Parameters:
- WIDTH, 16, operand/result width in bits. Two's-complement signed. All values in this document assume 16.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- A  input  16  signed operand A
- B  input  16  signed operand B
- Opcode  input  4  operation select
- print  output  16  signed result, registered
- ov  output  1  overflow/error flag, registered

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - rst_n low forces print=0 and ov=0 immediately, independent of clk.
  - rst_n low mid-operation discards the pending result.
  - After rst_n rises, the first rising clk edge loads a new result.
- Latency and timing:
  - Combinational compute of (A, B, Opcode); registered on each rising clk edge.
  - Latency is 1 cycle: inputs stable before edge N appear on print/ov after edge N.
  - No enable and no handshake; a new operation may be issued every cycle.
- Opcode map (results wrap modulo 2^16):
  - 0 ADD: print=A+B. ov=1 when A and B have the same sign and the result sign differs.
  - 1 SUB: print=A-B. ov=1 when A and B have different signs and the result sign differs from A.
  - 2 MUL: compute the full 32-bit signed product; print=low 16 bits. ov=1 when the product is not the sign-extension of its low 16 bits.
  - 3 DIV: print=A/B, signed, truncated toward zero.
    - B=0: print=0, ov=1.
    - A=-32768 with B=-1: print=-32768, ov=1.
    - Otherwise ov=0.
  - 4 INC: print=A+1. ov=1 only when A=32767 (print becomes -32768).
  - 5 DEC: print=A-1. ov=1 only when A=-32768 (print becomes 32767).
  - 6 AND: print=A&B, ov=0.
  - 7 XOR: print=A^B, ov=0.
  - 8 OR: print=A|B, ov=0.
  - 9 COMPLEMENT: print=~A (one's complement), ov=0.
  - 10-15: reserved; print=0, ov=0.
- B is ignored for opcodes 4, 5 and 9.
- Opcode change between cycles has no side effects; each cycle is independent and carries no state other than the output registers.
- Division is combinational within one cycle (no multicycle divider).

Test Plan:
- Reset: assert rst_n=0 asynchronously while print holds a nonzero value -> print=0, ov=0 immediately. Release rst_n, apply Opcode=0, A=36, B=25 -> after 1 clock, print=61, ov=0.
- ADD/SUB overflow:
  - ADD 12000+12000 -> 24000, ov=0.
  - ADD 32767+5000 -> -27769, ov=1.
  - ADD -32767+1 -> -32766, ov=0.
  - SUB 30000-2500 -> 27500, ov=0.
  - SUB A=32000, B=16'd33000 (=-32536) -> -1000, ov=1.
- MUL/DIV:
  - MUL 36*0 -> 0, ov=0.
  - MUL 300*-200 -> 5536, ov=1.
  - MUL -326*100 -> -32600, ov=0.
  - DIV -7000/3 -> -2333, ov=0.
  - DIV 6533/0 -> 0, ov=1.
  - DIV -32768/-1 -> -32768, ov=1.
- INC/DEC edges:
  - INC 32766 -> 32767, ov=0.
  - INC 32767 -> -32768, ov=1.
  - DEC -7000 -> -7001, ov=0.
  - DEC -32767 -> -32768, ov=0.
  - DEC -32768 -> 32767, ov=1.
- Logic:
  - AND 36,25 -> 0.
  - XOR 36,25 -> 61.
  - OR 36,25 -> 61.
  - AND 12000,12000 -> 12000.
  - XOR 12000,12000 -> 0.
  - OR -32767,1 -> -32767.
  - COMPLEMENT 36 -> -37.
  - COMPLEMENT -32767 -> 32766.
  - All with ov=0.
- Reserved/back-to-back:
  - Opcode=12, A=5, B=5 -> print=0, ov=0.
  - Alternate opcodes 0 and 1 every cycle -> each result appears exactly 1 cycle after its inputs.
